// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared state encoding and derived constants for the ME scan address generator
package me_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } me_state_e;

    localparam int TB_W_DEF = 16;
    localparam int TB_H_DEF = 16;
    localparam int SW_W_DEF = 48;
    localparam int SW_H_DEF = 48;

    localparam int N_CX   = SW_W_DEF - TB_W_DEF + 1;
    localparam int N_CY   = SW_H_DEF - TB_H_DEF + 1;
    localparam int TB_PIX = TB_W_DEF * TB_H_DEF;

    function automatic int n_cand(input int sw, input int tb);
        return sw - tb + 1;
    endfunction

    // Bits needed to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/me_wrap_cnt.sv
// rtl/me_wrap_cnt.sv - clear/enable counter that wraps at MAX and flags terminal count
module me_wrap_cnt #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    assign tc = (cnt == W'(MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/me_scan_addr_gen.sv
// rtl/me_scan_addr_gen.sv - raster full-search candidate walker emitting TB and SW pixel addresses
module me_scan_addr_gen
    import me_pkg::*;
#(
    parameter int TB_W    = 16,
    parameter int TB_H    = 16,
    parameter int SW_W    = 48,
    parameter int SW_H    = 48,
    parameter int ADDR_SW = 12,
    parameter int ADDR_TB = 8,
    parameter int CW      = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               clr,
    input  logic               en,
    output logic [ADDR_SW-1:0] addr_sw,
    output logic [ADDR_TB-1:0] addr_tb,
    output logic               valid,
    output logic               first_pix,
    output logic               last_pix,
    output logic [CW-1:0]      cand_x,
    output logic [CW-1:0]      cand_y,
    output logic               busy,
    output logic               done
);

    localparam int CX_CNT = n_cand(SW_W, TB_W);
    localparam int CY_CNT = n_cand(SW_H, TB_H);
    localparam int PXW    = cnt_width(TB_W);
    localparam int PYW    = cnt_width(TB_H);
    localparam logic [ADDR_SW-1:0] SW_STRIDE = ADDR_SW'(SW_W);

    me_state_e state;

    logic           beat, final_beat, cnt_clr;
    logic [PXW-1:0] px, px_nxt;
    logic [PYW-1:0] py, py_nxt;
    logic           px_tc, py_tc, cx_tc, cy_tc;
    logic           first_nxt, last_nxt;

    // line_base = cy*SW_W, cand_base = line_base+cx, row_base = cand_base+py*SW_W
    logic [ADDR_SW-1:0] line_base, cand_base, row_base;

    assign beat       = (state == ST_SCAN) && valid && en;
    assign final_beat = beat && px_tc && py_tc && cx_tc && cy_tc;
    assign cnt_clr    = clr || (state != ST_SCAN);

    me_wrap_cnt #(.W(PXW), .MAX(TB_W - 1)) u_px (
        .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .en(beat),
        .cnt(px), .tc(px_tc)
    );

    me_wrap_cnt #(.W(PYW), .MAX(TB_H - 1)) u_py (
        .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .en(beat && px_tc),
        .cnt(py), .tc(py_tc)
    );

    me_wrap_cnt #(.W(CW), .MAX(CX_CNT - 1)) u_cx (
        .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .en(beat && px_tc && py_tc),
        .cnt(cand_x), .tc(cx_tc)
    );

    me_wrap_cnt #(.W(CW), .MAX(CY_CNT - 1)) u_cy (
        .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .en(beat && px_tc && py_tc && cx_tc),
        .cnt(cand_y), .tc(cy_tc)
    );

    always_comb begin
        px_nxt    = px_tc ? '0 : px + 1'b1;
        py_nxt    = px_tc ? (py_tc ? '0 : py + 1'b1) : py;
        first_nxt = px_tc && py_tc;
        last_nxt  = (px_nxt == PXW'(TB_W - 1)) && (py_nxt == PYW'(TB_H - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            first_pix <= 1'b0;
            last_pix  <= 1'b0;
            addr_sw   <= '0;
            addr_tb   <= '0;
            line_base <= '0;
            cand_base <= '0;
            row_base  <= '0;
        end else if (clr) begin
            state     <= ST_IDLE;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            first_pix <= 1'b0;
            last_pix  <= 1'b0;
            addr_sw   <= '0;
            addr_tb   <= '0;
            line_base <= '0;
            cand_base <= '0;
            row_base  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_SCAN;
                        valid     <= 1'b1;
                        busy      <= 1'b1;
                        first_pix <= 1'b1;
                        last_pix  <= (TB_W == 1) && (TB_H == 1);
                        addr_sw   <= '0;
                        addr_tb   <= '0;
                        line_base <= '0;
                        cand_base <= '0;
                        row_base  <= '0;
                    end
                end
                ST_SCAN: begin
                    if (final_beat) begin
                        // Addresses deliberately hold their last values here.
                        state     <= ST_DONE;
                        valid     <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        first_pix <= 1'b0;
                        last_pix  <= 1'b0;
                    end else if (beat) begin
                        first_pix <= first_nxt;
                        last_pix  <= last_nxt;
                        if (!px_tc) begin
                            addr_sw <= addr_sw + 1'b1;
                            addr_tb <= addr_tb + 1'b1;
                        end else if (!py_tc) begin
                            row_base <= row_base + SW_STRIDE;
                            addr_sw  <= row_base + SW_STRIDE;
                            addr_tb  <= addr_tb + 1'b1;
                        end else if (!cx_tc) begin
                            cand_base <= cand_base + 1'b1;
                            row_base  <= cand_base + 1'b1;
                            addr_sw   <= cand_base + 1'b1;
                            addr_tb   <= '0;
                        end else begin
                            line_base <= line_base + SW_STRIDE;
                            cand_base <= line_base + SW_STRIDE;
                            row_base  <= line_base + SW_STRIDE;
                            addr_sw   <= line_base + SW_STRIDE;
                            addr_tb   <= '0;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_me_scan_addr_gen.sv
// tb/tb_me_scan_addr_gen.sv - randomized self-checking bench against a nested-loop scan model
module tb_me_scan_addr_gen;

    localparam int TB_W    = 2;
    localparam int TB_H    = 2;
    localparam int SW_W    = 4;
    localparam int SW_H    = 3;
    localparam int ADDR_SW = 4;
    localparam int ADDR_TB = 2;
    localparam int CW      = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               clr = 1'b0;
    logic               en = 1'b0;
    logic [ADDR_SW-1:0] addr_sw;
    logic [ADDR_TB-1:0] addr_tb;
    logic               valid, first_pix, last_pix, busy, done;
    logic [CW-1:0]      cand_x, cand_y;

    int vectors = 0;
    int miscompares = 0;

    int exp_sw[$], exp_tb[$], exp_cx[$], exp_cy[$], exp_first[$], exp_last[$];
    int n_beats;

    me_scan_addr_gen #(
        .TB_W(TB_W), .TB_H(TB_H), .SW_W(SW_W), .SW_H(SW_H),
        .ADDR_SW(ADDR_SW), .ADDR_TB(ADDR_TB), .CW(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .en(en),
        .addr_sw(addr_sw), .addr_tb(addr_tb), .valid(valid),
        .first_pix(first_pix), .last_pix(last_pix),
        .cand_x(cand_x), .cand_y(cand_y), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, int'(valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_sw"}, int'(addr_sw), 0);
        check({tag, "_tb"}, int'(addr_tb), 0);
        check({tag, "_cx"}, int'(cand_x), 0);
        check({tag, "_cy"}, int'(cand_y), 0);
        check({tag, "_first"}, int'(first_pix), 0);
        check({tag, "_last"}, int'(last_pix), 0);
    endtask

    // en_pct: probability of en per cycle; clr_at: beat index to abort at (-1 none);
    // poke: also throw spurious start pulses during the scan and in the DONE cycle.
    task automatic run_scan(input int en_pct, input int clr_at, input bit poke);
        int  idx = 0;
        int  cyc = 0;
        bit  aborted = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (valid && cyc < 1000) begin
            if (idx >= n_beats) begin
                check("beat_overrun", idx, n_beats - 1);
                break;
            end
            check("sw", int'(addr_sw), exp_sw[idx]);
            check("tb", int'(addr_tb), exp_tb[idx]);
            check("cx", int'(cand_x), exp_cx[idx]);
            check("cy", int'(cand_y), exp_cy[idx]);
            check("first", int'(first_pix), exp_first[idx]);
            check("last", int'(last_pix), exp_last[idx]);
            check("busy", int'(busy), 1);
            check("done_early", int'(done), 0);
            en    = ($urandom_range(99) < en_pct);
            start = poke ? 1'($urandom_range(1)) : 1'b0;
            clr   = (idx == clr_at);
            tick();
            start = 1'b0;
            if (clr) begin
                clr = 1'b0;
                aborted = 1;
                break;
            end
            if (en) idx++;
            cyc++;
        end
        if (cyc >= 1000) check("timeout", cyc, 0);
        en = 1'b0;
        if (aborted) begin
            check_all_zero("clr");
            tick();
            check("clr_no_done", int'(done), 0);
        end else begin
            check("beats", idx, n_beats);
            check("done_pulse", int'(done), 1);
            check("busy_fall", int'(busy), 0);
            check("valid_fall", int'(valid), 0);
            check("hold_sw", int'(addr_sw), exp_sw[n_beats-1]);
            check("hold_tb", int'(addr_tb), exp_tb[n_beats-1]);
            start = poke;
            tick();
            start = 1'b0;
            check("done_once", int'(done), 0);
            check("idle_valid", int'(valid), 0);
        end
    endtask

    initial begin
        for (int cy = 0; cy <= SW_H - TB_H; cy++)
            for (int cx = 0; cx <= SW_W - TB_W; cx++)
                for (int py = 0; py < TB_H; py++)
                    for (int px = 0; px < TB_W; px++) begin
                        exp_sw.push_back((cy + py) * SW_W + cx + px);
                        exp_tb.push_back(py * TB_W + px);
                        exp_cx.push_back(cx);
                        exp_cy.push_back(cy);
                        exp_first.push_back((px == 0 && py == 0) ? 1 : 0);
                        exp_last.push_back((px == TB_W - 1 && py == TB_H - 1) ? 1 : 0);
                    end
        n_beats = exp_sw.size();

        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_no_start", int'(valid), 0);

        run_scan(100, -1, 0);
        run_scan(60, -1, 0);
        run_scan(50, -1, 1);
        run_scan(100, 10, 0);
        run_scan(70, -1, 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("pre_rst_valid", int'(valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("post_rst_idle_valid", int'(valid), 0);
        check("post_rst_idle_busy", int'(busy), 0);

        run_scan(80, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
